// File: rtl/jk_pkg.sv
// Shared definitions for the JK command sequencer: op codes, {j,k} drive
// patterns, FSM state encoding and the op-to-drive mapping.
package jk_pkg;

   typedef enum logic [1:0] {
      JK_OP_HOLD = 2'd0,
      JK_OP_CLR  = 2'd1,
      JK_OP_SET  = 2'd2,
      JK_OP_TOG  = 2'd3
   } jk_op_e;

   localparam logic [1:0] JK_DRV_HOLD = 2'b00;
   localparam logic [1:0] JK_DRV_CLR  = 2'b01;
   localparam logic [1:0] JK_DRV_SET  = 2'b10;
   localparam logic [1:0] JK_DRV_TOG  = 2'b11;

   typedef enum logic {
      JK_ST_IDLE  = 1'b0,
      JK_ST_DRIVE = 1'b1
   } jk_state_e;

   function automatic logic [1:0] jk_op_drive(input jk_op_e op);
      logic [1:0] drv;
      case (op)
         JK_OP_HOLD: drv = JK_DRV_HOLD;
         JK_OP_CLR:  drv = JK_DRV_CLR;
         JK_OP_SET:  drv = JK_DRV_SET;
         JK_OP_TOG:  drv = JK_DRV_TOG;
         default:    drv = JK_DRV_HOLD;
      endcase
      return drv;
   endfunction

endpackage

// File: rtl/jk_shadow.sv
// Shadow model of the downstream JK flip-flop's q plus a sticky mismatch flag
// comparing it against the fed-back q. Built only with JK_CMD_SEQ_CHECK_EN.
module jk_shadow
   import jk_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_jk,
   input  logic       i_q_fb,
   input  logic       i_clr_err,
   output logic       o_q_exp,
   output logic       o_mismatch
);

   logic r_q_exp;
   logic r_mismatch;
   logic w_q_exp_nxt;
   logic w_mismatch_nxt;

   // Next q follows JK semantics applied to the drive currently presented.
   always_comb begin
      w_q_exp_nxt = r_q_exp;
      case (i_jk)
         JK_DRV_HOLD: w_q_exp_nxt = r_q_exp;
         JK_DRV_CLR:  w_q_exp_nxt = 1'b0;
         JK_DRV_SET:  w_q_exp_nxt = 1'b1;
         JK_DRV_TOG:  w_q_exp_nxt = ~r_q_exp;
         default:     w_q_exp_nxt = r_q_exp;
      endcase
   end

   // A fresh divergence takes priority over a clear request in the same cycle.
   always_comb begin
      w_mismatch_nxt = r_mismatch;
      if (i_q_fb != r_q_exp) begin
         w_mismatch_nxt = 1'b1;
      end else if (i_clr_err) begin
         w_mismatch_nxt = 1'b0;
      end else begin
         w_mismatch_nxt = r_mismatch;
      end
   end

   // Shadow and flag registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q_exp    <= 1'b0;
         r_mismatch <= 1'b0;
      end else begin
         r_q_exp    <= w_q_exp_nxt;
         r_mismatch <= w_mismatch_nxt;
      end
   end

   assign o_q_exp    = r_q_exp;
   assign o_mismatch = r_mismatch;

endmodule

// File: rtl/jk_cmd_seq.sv
// Command sequencer driving a JK flip-flop's j/k for L+1 cycles per command.
// Define JK_CMD_SEQ_CHECK_EN to build the q shadow model and mismatch checker.
module jk_cmd_seq
   import jk_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_len,
   output logic             j,
   output logic             k,
   output logic             busy,
   input  logic             q_fb,
   output logic             q_exp,
   output logic             mismatch,
   input  logic             clr_err
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   jk_state_e        r_state;
   jk_state_e        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   jk_op_e           r_op;
   jk_op_e           w_op_nxt;
   logic [1:0]       r_jk;
   logic [1:0]       w_jk_nxt;
   logic             r_busy;
   logic             w_busy_nxt;
   logic             r_ready;
   logic             w_ready_nxt;
   logic             w_accept;

   assign w_accept = cmd_valid && r_ready;

   // State register; outputs are registered alongside so they change on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= JK_ST_IDLE;
         r_cnt   <= CNT_ZERO;
         r_op    <= JK_OP_HOLD;
         r_jk    <= JK_DRV_HOLD;
         r_busy  <= 1'b0;
         r_ready <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_op    <= w_op_nxt;
         r_jk    <= w_jk_nxt;
         r_busy  <= w_busy_nxt;
         r_ready <= w_ready_nxt;
      end
   end

   // Next state: the last drive cycle can accept a follow-on command with no bubble.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_op_nxt    = r_op;
      case (r_state)
         JK_ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = JK_ST_DRIVE;
               w_cnt_nxt   = cmd_len;
               w_op_nxt    = jk_op_e'(cmd_op);
            end else begin
               w_state_nxt = JK_ST_IDLE;
            end
         end
         JK_ST_DRIVE: begin
            if (r_cnt != CNT_ZERO) begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end else if (w_accept) begin
               w_cnt_nxt = cmd_len;
               w_op_nxt  = jk_op_e'(cmd_op);
            end else begin
               w_state_nxt = JK_ST_IDLE;
               w_cnt_nxt   = CNT_ZERO;
               w_op_nxt    = JK_OP_HOLD;
            end
         end
         default: begin
            w_state_nxt = JK_ST_IDLE;
            w_cnt_nxt   = CNT_ZERO;
            w_op_nxt    = JK_OP_HOLD;
         end
      endcase
   end

   // Output values derived from the upcoming state, captured by the register above.
   always_comb begin
      w_busy_nxt  = (w_state_nxt == JK_ST_DRIVE);
      w_ready_nxt = (w_state_nxt == JK_ST_IDLE) || (w_cnt_nxt == CNT_ZERO);
      if (w_state_nxt == JK_ST_DRIVE) begin
         w_jk_nxt = jk_op_drive(w_op_nxt);
      end else begin
         w_jk_nxt = JK_DRV_HOLD;
      end
   end

   assign j         = r_jk[1];
   assign k         = r_jk[0];
   assign busy      = r_busy;
   assign cmd_ready = r_ready;

`ifdef JK_CMD_SEQ_CHECK_EN
   jk_shadow u_shadow (
      .i_clk      (clk),
      .i_rst_n    (reset),
      .i_jk       (r_jk),
      .i_q_fb     (q_fb),
      .i_clr_err  (clr_err),
      .o_q_exp    (q_exp),
      .o_mismatch (mismatch)
   );
`else
   logic w_unused_chk;
   assign w_unused_chk = q_fb ^ clr_err;
   assign q_exp        = 1'b0;
   assign mismatch     = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Self-checking bench for jk_cmd_seq: queue-based reference model, a JK
// flip-flop feeding q_fb back, and directed vectors with literal expectations.
module tb_jk_cmd_seq;

   localparam int CNT_W = 4;
`ifdef JK_CMD_SEQ_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_len;
   logic             j, k, busy;
   logic             q_fb, q_exp, mismatch, clr_err;
   logic             q_ff;
   logic             err_inj;

   int tests = 0;
   int fails = 0;

   jk_cmd_seq #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_len(cmd_len), .j(j), .k(k), .busy(busy),
      .q_fb(q_fb), .q_exp(q_exp), .mismatch(mismatch), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   // Downstream JK flip-flop; err_inj corrupts the feedback path.
   always @(posedge clk or negedge reset) begin
      if (!reset) q_ff <= 1'b0;
      else begin
         case ({j, k})
            2'b01:   q_ff <= 1'b0;
            2'b10:   q_ff <= 1'b1;
            2'b11:   q_ff <= ~q_ff;
            default: q_ff <= q_ff;
         endcase
      end
   end
   assign q_fb = q_ff ^ err_inj;

   // Reference model: a queue holding the drive for every remaining cycle.
   logic [1:0] m_q[$];
   logic       m_qexp, m_mism;
   logic [1:0] m_cur;
   bit         m_acc;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_q.delete();
         m_qexp = 1'b0;
         m_mism = 1'b0;
      end else begin
         m_cur = (m_q.size() > 0) ? m_q[0] : 2'b00;
         m_acc = cmd_valid && (m_q.size() <= 1);
         if (CHK) begin
            if (q_fb != m_qexp) m_mism = 1'b1;
            else if (clr_err)   m_mism = 1'b0;
            if (m_cur == 2'b01)      m_qexp = 1'b0;
            else if (m_cur == 2'b10) m_qexp = 1'b1;
            else if (m_cur == 2'b11) m_qexp = ~m_qexp;
         end
         if (m_q.size() > 0) void'(m_q.pop_front());
         if (m_acc) for (int i = 0; i <= int'(cmd_len); i++) m_q.push_back(cmd_op);
      end
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         chk("model_jk",    {6'd0, j, k}, {6'd0, (m_q.size() > 0) ? m_q[0] : 2'b00});
         chk("model_busy",  {7'd0, busy},      {7'd0, m_q.size() > 0});
         chk("model_ready", {7'd0, cmd_ready}, {7'd0, m_q.size() <= 1});
         chk("model_qexp",  {7'd0, q_exp},     {7'd0, m_qexp});
         chk("model_mism",  {7'd0, mismatch},  {7'd0, m_mism});
      end
   end

   task automatic issue(input logic [1:0] op, input logic [CNT_W-1:0] len);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_len   = len;
   endtask

   logic [1:0] tc [7] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00};

   initial begin
      reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = '0;
      clr_err = 1'b0; err_inj = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_j", {7'd0, j}, 8'd0);
      chk("rst_k", {7'd0, k}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_ready", {7'd0, cmd_ready}, 8'd1);
      chk("rst_qexp", {7'd0, q_exp}, 8'd0);
      chk("rst_mism", {7'd0, mismatch}, 8'd0);
      #2 reset = 1'b1;

      // SET L=0 accepted on the first edge after reset release
      issue(2'd2, 4'd0);
      @(negedge clk); cmd_valid = 1'b0;
      chk("set0_jk", {6'd0, j, k}, 8'h02);
      chk("set0_busy", {7'd0, busy}, 8'd1);
      @(negedge clk);
      chk("set0_jk_after", {6'd0, j, k}, 8'h00);
      chk("set0_busy_after", {7'd0, busy}, 8'd0);
      chk("set0_qexp", {7'd0, q_exp}, {7'd0, CHK});
      @(negedge clk);
      chk("set0_qexp_hold", {7'd0, q_exp}, {7'd0, CHK});

      // Reset mid-DRIVE on SET L=7 after three drive cycles
      issue(2'd2, 4'd7);
      @(negedge clk); cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("mrst_j", {7'd0, j}, 8'd0);
      chk("mrst_k", {7'd0, k}, 8'd0);
      chk("mrst_busy", {7'd0, busy}, 8'd0);
      chk("mrst_ready", {7'd0, cmd_ready}, 8'd1);
      chk("mrst_qexp", {7'd0, q_exp}, 8'd0);
      @(negedge clk);
      #2 reset = 1'b1;

      // TOG L=3 chained back-to-back with CLR L=1
      issue(2'd3, 4'd3);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (i == 0) issue(2'd1, 4'd1);
         if (i == 4) cmd_valid = 1'b0;
         chk($sformatf("chain_jk%0d", i), {6'd0, j, k}, {6'd0, tc[i]});
         if (i == 3) chk("chain_qexp3", {7'd0, q_exp}, {7'd0, CHK});
         if (i == 4 || i == 6) chk("chain_qexp_end", {7'd0, q_exp}, 8'd0);
      end

      // SET L=3 with a TOG pulse while count is nonzero (must be ignored)
      @(negedge clk); issue(2'd2, 4'd3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) cmd_valid = 1'b0;
         if (i == 1) issue(2'd3, 4'd5);
         if (i == 2) cmd_valid = 1'b0;
         chk($sformatf("pulse_jk%0d", i), {6'd0, j, k}, (i < 4) ? 8'h02 : 8'h00);
      end
      chk("pulse_busy_end", {7'd0, busy}, 8'd0);

      // Maximum length: TOG L=15 drives exactly 16 cycles
      @(negedge clk); issue(2'd3, 4'd15);
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         if (i == 0) cmd_valid = 1'b0;
         chk($sformatf("max_jk%0d", i), {6'd0, j, k}, (i < 16) ? 8'h03 : 8'h00);
      end
      chk("max_qexp", {7'd0, q_exp}, {7'd0, CHK});

      // Mismatch detection, stickiness, clear, and set-over-clear priority
      @(negedge clk); issue(2'd1, 4'd0);
      @(negedge clk); cmd_valid = 1'b0;
      @(negedge clk); err_inj = 1'b1;
      @(negedge clk); chk("mism_set", {7'd0, mismatch}, {7'd0, CHK}); err_inj = 1'b0;
      @(negedge clk); chk("mism_sticky", {7'd0, mismatch}, {7'd0, CHK}); clr_err = 1'b1;
      @(negedge clk); chk("mism_clr", {7'd0, mismatch}, 8'd0); err_inj = 1'b1;
      @(negedge clk); chk("mism_set_wins", {7'd0, mismatch}, {7'd0, CHK});
      err_inj = 1'b0; clr_err = 1'b0;
      @(negedge clk); chk("mism_hold", {7'd0, mismatch}, {7'd0, CHK}); clr_err = 1'b1;
      @(negedge clk); chk("mism_clr2", {7'd0, mismatch}, 8'd0); clr_err = 1'b0;

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
